word_packer: RTL and testbench
==============================

# word_packer

Upstream feeder for the 6-in/1-out word FIFO. It accepts one `DATAWIDTH`-bit word per cycle on a valid/ready stream and packs `PACK` consecutive words into one wide group. Each group goes out on the FIFO's `din`/`din_valid` write port. A two-stage buffer (accumulator plus output holding register) keeps accepting words while a finished group waits for FIFO space.

## Interface
- `DATAWIDTH`, 192, width of one word
- `PACK`, 6, words per group; must equal the FIFO's `IN_SIZE`; ≥2
- `CNT_WIDTH`, `$clog2(PACK+1)`, localparam width of `fill_count`
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `s_data`  in  DATAWIDTH  input word
- `s_valid`  in  1  `s_data` valid
- `s_ready`  out  1  packer can accept a word this cycle
- `f_din`  out  DATAWIDTH*PACK  packed group; word 0 in bits `[DATAWIDTH-1:0]`
- `f_din_valid`  out  1  `f_din` holds a pending group
- `f_full`  in  1  FIFO full; group not written while high
- `fill_count`  out  CNT_WIDTH  words currently in accumulator (0..PACK)
- `group_cnt`  out  16  groups handed to FIFO, wraps at 65535→0
- `flush`  in  1  present only with `WORD_PACKER_FLUSH_EN`

## Operation
- Accept: `s_valid && s_ready`. Word number k of a group (k=0 first) goes to slice `[DATAWIDTH*k +: DATAWIDTH]`. This matches the FIFO's low-slice-first read order.
- Drain: `f_din_valid && !f_full`. The FIFO latches the group on this edge. `pending` (= `f_din_valid`) clears unless reloaded the same cycle.
- `out_free = !pending || drain`.
- States:
  - FILL (`fill_count` < PACK): `s_ready`=1.
  - STALL (`fill_count` == PACK): `s_ready`=0. Accumulator is complete but the output register is occupied.
- FILL, accept with `fill_count`==PACK-1:
  - If `out_free`, load the output register with {`s_data`, accumulator slices 0..PACK-2}, set `pending`, set `fill_count` to 0, stay in FILL.
  - Otherwise store the word, set `fill_count` to PACK, go to STALL.
- STALL, when `out_free`: move the accumulator to the output register, set `pending`, set `fill_count` to 0, go to FILL.
- Accumulator slices not yet written in the current group hold stale data. They are never emitted except zero-padded under flush.
- `group_cnt` increments on every drain.
- Simultaneous drain and load: the new group replaces the old one, and `f_din_valid` stays high with no bubble.
- Reset (`rst_n` low at an edge, including mid-group): `fill_count`=0, `pending`=0, `f_din`=0, `group_cnt`=0, state FILL. Partial groups are discarded. `s_ready` is forced 0 while `rst_n` is low.

## Timing
- Reset values: `s_ready` 0 during reset and 1 on the first cycle after release; `f_din_valid` 0; `f_din` 0; `fill_count` 0; `group_cnt` 0.
- Latency: edge accepting the last word of a group → `f_din_valid` high on the next cycle, when `out_free`.
- Sustained throughput: 1 word/cycle while `f_full` is low at least 1 cycle in PACK.
- `s_ready` depends only on registered state, with no combinational path from `s_valid`. `f_din_valid` is registered. `f_full` affects only next-state logic.
- `s_ready` falls in the cycle after entering STALL. It rises in the cycle after the accumulator transfers.

## Configuration
- `WORD_PACKER_FLUSH_EN` defined:
  - The `flush` port exists.
  - Flush in FILL with `fill_count`>0, or with an accept in the same cycle: the group is closed. The word accepted that cycle is included. Unfilled slices are zeroed. It follows the normal load/STALL rules as if the group were complete, and `fill_count` goes to 0 on load.
  - Flush with `fill_count`==0 and no accept: ignored.
  - Flush in STALL: ignored.
- Macro undefined: no `flush` port; groups are emitted only when complete.

## Test plan
- Reset, then words 1..6 on consecutive cycles, `f_full`=0 → one cycle after word 6, `f_din` = {6,5,4,3,2,1} (word 1 in low slice), `f_din_valid`=1 for 1 cycle, `group_cnt`=1.
- 18 back-to-back words, `f_full`=0 → three groups, `s_ready` never drops, `group_cnt`=3.
- `f_full` held 1 while 12 words are offered → first group pending, second in accumulator, `s_ready`=0 and `fill_count`=6. Release `f_full` → groups drain in order on consecutive cycles, then `s_ready`=1.
- 3 words accepted, then `rst_n` low 1 cycle, then words 7..12 → emitted group = {12..7}, and no trace of the partial group.
- With `WORD_PACKER_FLUSH_EN`: words 1,2, then `flush` with word 3 accepted → `f_din` = {0,0,0,3,2,1}. Flush with `fill_count`=0 → no output.
- With `WORD_PACKER_FLUSH_EN`: flush asserted in STALL → ignored, and the accumulated full group is emitted unchanged once `f_full` drops.

Source files
------------

// File: rtl/word_packer.sv
// Packs PACK consecutive DATAWIDTH-bit stream words into one wide group for the word FIFO write port.
// Optional early group close via the flush input when WORD_PACKER_FLUSH_EN is defined.
module word_packer #(
    parameter int DATAWIDTH = 192,
    parameter int PACK      = 6,
    localparam int CNT_WIDTH = $clog2(PACK + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATAWIDTH-1:0]        s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [DATAWIDTH*PACK-1:0]   f_din,
    output logic                        f_din_valid,
    input  logic                        f_full,
    output logic [CNT_WIDTH-1:0]        fill_count,
`ifdef WORD_PACKER_FLUSH_EN
    input  logic                        flush,
`endif
    output logic [15:0]                 group_cnt
);

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t                      state;
    state_t                      next_state;
    logic [CNT_WIDTH-1:0]        next_fill;
    logic [DATAWIDTH*PACK-1:0]   acc;
    logic [DATAWIDTH*PACK-1:0]   next_group;
    logic                        pending;

    logic accept;
    logic drain;
    logic out_free;
    logic word_close;
    logic flush_close;
    logic close;
    logic load_new;
    logic load_acc;
    logic park;
    logic store_word;

    assign s_ready     = rst_n && (state == FILL);
    assign f_din_valid = pending;
    assign accept      = s_valid && s_ready;
    assign drain       = pending && !f_full;
    assign out_free    = !pending || drain;
    assign word_close  = accept && (fill_count == CNT_WIDTH'(PACK - 1));

`ifdef WORD_PACKER_FLUSH_EN
    // A flush only closes a group that has (or is receiving) at least one word.
    assign flush_close = flush && (state == FILL) && ((fill_count != '0) || accept);
`else
    assign flush_close = 1'b0;
`endif

    assign close = word_close || flush_close;

    // Group as it would look if closed this cycle: filled slices, the incoming word, zeros above.
    always_comb begin
        next_group = '0;
        for (int k = 0; k < PACK; k++) begin
            if (CNT_WIDTH'(k) < fill_count)
                next_group[DATAWIDTH*k +: DATAWIDTH] = acc[DATAWIDTH*k +: DATAWIDTH];
            else if ((CNT_WIDTH'(k) == fill_count) && accept)
                next_group[DATAWIDTH*k +: DATAWIDTH] = s_data;
        end
    end

    always_comb begin
        next_state = state;
        next_fill  = fill_count;
        load_new   = 1'b0;
        load_acc   = 1'b0;
        park       = 1'b0;
        store_word = 1'b0;
        case (state)
            FILL: begin
                if (close) begin
                    if (out_free) begin
                        load_new  = 1'b1;
                        next_fill = '0;
                    end else begin
                        park       = 1'b1;
                        next_fill  = CNT_WIDTH'(PACK);
                        next_state = STALL;
                    end
                end else if (accept) begin
                    store_word = 1'b1;
                    next_fill  = fill_count + CNT_WIDTH'(1);
                end
            end
            STALL: begin
                if (out_free) begin
                    load_acc   = 1'b1;
                    next_fill  = '0;
                    next_state = FILL;
                end
            end
            default: begin
                next_state = FILL;
                next_fill  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FILL;
            fill_count <= '0;
        end else begin
            state      <= next_state;
            fill_count <= next_fill;
        end
    end

    // A load on the same edge as a drain replaces the group, so pending stays high without a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            f_din     <= '0;
            group_cnt <= '0;
        end else begin
            if (drain)
                group_cnt <= group_cnt + 16'd1;
            if (load_new) begin
                f_din   <= next_group;
                pending <= 1'b1;
            end else if (load_acc) begin
                f_din   <= acc;
                pending <= 1'b1;
            end else if (drain) begin
                pending <= 1'b0;
            end
        end
    end

    // Accumulator needs no reset: fill_count alone marks which slices are meaningful.
    always_ff @(posedge clk) begin
        if (park) begin
            acc <= next_group;
        end else if (store_word) begin
            for (int k = 0; k < PACK; k++) begin
                if (CNT_WIDTH'(k) == fill_count)
                    acc[DATAWIDTH*k +: DATAWIDTH] <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_word_packer.sv
// Directed self-checking bench for word_packer; flush scenarios run only when WORD_PACKER_FLUSH_EN is defined.
module tb_word_packer;

    localparam int DW = 192;
    localparam int PK = 6;
    localparam int GW = DW * PK;

    typedef logic [GW-1:0] wide_t;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [GW-1:0] f_din;
    logic          f_din_valid;
    logic          f_full;
    logic [2:0]    fill_count;
    logic [15:0]   group_cnt;
`ifdef WORD_PACKER_FLUSH_EN
    logic          flush;
`endif

    int checks = 0;
    int errors = 0;
    int ready_drops;

    word_packer #(
        .DATAWIDTH(DW),
        .PACK     (PK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .f_din      (f_din),
        .f_din_valid(f_din_valid),
        .f_full     (f_full),
        .fill_count (fill_count),
`ifdef WORD_PACKER_FLUSH_EN
        .flush      (flush),
`endif
        .group_cnt  (group_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic wide_t mkGroup(input int w0, input int w1, input int w2,
                                      input int w3, input int w4, input int w5);
        wide_t g;
        g = '0;
        g[DW*0 +: DW] = DW'(w0);
        g[DW*1 +: DW] = DW'(w1);
        g[DW*2 +: DW] = DW'(w2);
        g[DW*3 +: DW] = DW'(w3);
        g[DW*4 +: DW] = DW'(w4);
        g[DW*5 +: DW] = DW'(w5);
        return g;
    endfunction

    // Drive inputs, clock once, then return 1 time unit after the edge where outputs are stable.
    task automatic applyStimulus(input logic valid, input int word, input logic full);
        s_valid = valid;
        s_data  = DW'(word);
        f_full  = full;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input wide_t observed, input wide_t expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        f_full  = 1'b0;
`ifdef WORD_PACKER_FLUSH_EN
        flush   = 1'b0;
`endif
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("reset_s_ready", wide_t'(s_ready), wide_t'(0));
        checkOutput("reset_valid", wide_t'(f_din_valid), wide_t'(0));
        checkOutput("reset_din", f_din, '0);
        checkOutput("reset_fill", wide_t'(fill_count), wide_t'(0));
        checkOutput("reset_gcnt", wide_t'(group_cnt), wide_t'(0));
        rst_n = 1'b1;
        #1;
        checkOutput("release_s_ready", wide_t'(s_ready), wide_t'(1));

        $display("[TB] single group 1..6");
        for (int w = 1; w <= 6; w++) begin
            applyStimulus(1, w, 0);
            if (w == 3)
                checkOutput("fill_after_3", wide_t'(fill_count), wide_t'(3));
        end
        checkOutput("g1_valid", wide_t'(f_din_valid), wide_t'(1));
        checkOutput("g1_din", f_din, mkGroup(1, 2, 3, 4, 5, 6));
        checkOutput("g1_fill", wide_t'(fill_count), wide_t'(0));
        applyStimulus(0, 0, 0);
        checkOutput("g1_valid_drop", wide_t'(f_din_valid), wide_t'(0));
        checkOutput("g1_gcnt", wide_t'(group_cnt), wide_t'(1));

        $display("[TB] 18 back-to-back words");
        ready_drops = 0;
        for (int w = 7; w <= 24; w++) begin
            if (!s_ready)
                ready_drops++;
            applyStimulus(1, w, 0);
            if (w == 12)
                checkOutput("b2b_g2_din", f_din, mkGroup(7, 8, 9, 10, 11, 12));
            if (w == 18)
                checkOutput("b2b_g3_din", f_din, mkGroup(13, 14, 15, 16, 17, 18));
        end
        checkOutput("b2b_ready_drops", wide_t'(ready_drops), wide_t'(0));
        checkOutput("b2b_g4_valid", wide_t'(f_din_valid), wide_t'(1));
        checkOutput("b2b_g4_din", f_din, mkGroup(19, 20, 21, 22, 23, 24));
        applyStimulus(0, 0, 0);
        checkOutput("b2b_gcnt", wide_t'(group_cnt), wide_t'(4));

        $display("[TB] backpressure with f_full held");
        for (int w = 25; w <= 36; w++)
            applyStimulus(1, w, 1);
        applyStimulus(0, 0, 1);
        checkOutput("bp_s_ready", wide_t'(s_ready), wide_t'(0));
        checkOutput("bp_fill", wide_t'(fill_count), wide_t'(6));
        checkOutput("bp_pending_din", f_din, mkGroup(25, 26, 27, 28, 29, 30));
        checkOutput("bp_gcnt_hold", wide_t'(group_cnt), wide_t'(4));
        applyStimulus(0, 0, 0);
        checkOutput("bp_second_valid", wide_t'(f_din_valid), wide_t'(1));
        checkOutput("bp_second_din", f_din, mkGroup(31, 32, 33, 34, 35, 36));
        checkOutput("bp_ready_back", wide_t'(s_ready), wide_t'(1));
        checkOutput("bp_gcnt_first", wide_t'(group_cnt), wide_t'(5));
        applyStimulus(0, 0, 0);
        checkOutput("bp_drained", wide_t'(f_din_valid), wide_t'(0));
        checkOutput("bp_gcnt_second", wide_t'(group_cnt), wide_t'(6));

        $display("[TB] reset mid-group");
        for (int w = 37; w <= 39; w++)
            applyStimulus(1, w, 0);
        checkOutput("mid_fill", wide_t'(fill_count), wide_t'(3));
        rst_n = 1'b0;
        applyStimulus(0, 0, 0);
        checkOutput("mid_rst_ready", wide_t'(s_ready), wide_t'(0));
        checkOutput("mid_rst_fill", wide_t'(fill_count), wide_t'(0));
        checkOutput("mid_rst_gcnt", wide_t'(group_cnt), wide_t'(0));
        rst_n = 1'b1;
        for (int w = 7; w <= 12; w++)
            applyStimulus(1, w, 0);
        checkOutput("mid_grp_valid", wide_t'(f_din_valid), wide_t'(1));
        checkOutput("mid_grp_din", f_din, mkGroup(7, 8, 9, 10, 11, 12));
        applyStimulus(0, 0, 0);
        checkOutput("mid_gcnt", wide_t'(group_cnt), wide_t'(1));

`ifdef WORD_PACKER_FLUSH_EN
        $display("[TB] flush closes partial group");
        applyStimulus(1, 1, 0);
        applyStimulus(1, 2, 0);
        flush = 1'b1;
        applyStimulus(1, 3, 0);
        flush = 1'b0;
        checkOutput("fl_valid", wide_t'(f_din_valid), wide_t'(1));
        checkOutput("fl_din", f_din, mkGroup(1, 2, 3, 0, 0, 0));
        checkOutput("fl_fill", wide_t'(fill_count), wide_t'(0));
        applyStimulus(0, 0, 0);
        checkOutput("fl_gcnt", wide_t'(group_cnt), wide_t'(2));
        flush = 1'b1;
        applyStimulus(0, 0, 0);
        flush = 1'b0;
        checkOutput("fl_empty_valid", wide_t'(f_din_valid), wide_t'(0));
        applyStimulus(0, 0, 0);
        checkOutput("fl_empty_gcnt", wide_t'(group_cnt), wide_t'(2));

        $display("[TB] flush during stall");
        for (int w = 41; w <= 52; w++)
            applyStimulus(1, w, 1);
        flush = 1'b1;
        applyStimulus(0, 0, 1);
        flush = 1'b0;
        checkOutput("fls_fill", wide_t'(fill_count), wide_t'(6));
        checkOutput("fls_pending_din", f_din, mkGroup(41, 42, 43, 44, 45, 46));
        applyStimulus(0, 0, 0);
        checkOutput("fls_second_din", f_din, mkGroup(47, 48, 49, 50, 51, 52));
        applyStimulus(0, 0, 0);
        checkOutput("fls_gcnt", wide_t'(group_cnt), wide_t'(4));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
